// File: rtl/alu_ovf_ctrl_if.sv
// alu_ovf_ctrl_if -- bundle of request, ALU-drive and status signals for alu_ovf_ctrl.
//
// Parameters:
//   WIDTH  operand/result width
//   CNT_W  overflow-event counter width
//
// Signals:
//   req, op_in, op_signed, A, B, pc_in      operation request from the requester
//   ALU_operation, alu_A, alu_B             drive towards the external ALU
//   alu_res, overflow                       ALU result and overflow-checker flag
//   busy, done, result, wr_en               completion status and write-back data
//   trap, epc, trap_ack, ovf_count          overflow trap handshake and statistics
//
// Modports:
//   slave   the controller side (alu_ovf_ctrl)
//   master  the requester/ALU environment side
interface alu_ovf_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic              req;
    logic [2:0]        op_in;
    logic              op_signed;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [WIDTH-1:0]  pc_in;

    logic [2:0]        ALU_operation;
    logic [WIDTH-1:0]  alu_A;
    logic [WIDTH-1:0]  alu_B;
    logic [WIDTH-1:0]  alu_res;
    logic              overflow;

    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              wr_en;
    logic              trap;
    logic [WIDTH-1:0]  epc;
    logic              trap_ack;
    logic [CNT_W-1:0]  ovf_count;

    modport slave (
        input  req, op_in, op_signed, A, B, pc_in, alu_res, overflow, trap_ack,
        output ALU_operation, alu_A, alu_B, busy, done, result, wr_en, trap, epc, ovf_count
    );

    modport master (
        output req, op_in, op_signed, A, B, pc_in, alu_res, overflow, trap_ack,
        input  ALU_operation, alu_A, alu_B, busy, done, result, wr_en, trap, epc, ovf_count
    );
endinterface

// File: rtl/alu_ovf_ctrl.sv
// alu_ovf_ctrl -- sequences one ALU operation per request and raises a
// precise trap when a signed add/sub overflows.
//
// Flow: IDLE -(req)-> ISSUE -> CAPTURE -> DONE -> IDLE
//                                     \-> TRAP -(trap_ack)-> IDLE
// The ALU result and overflow flag are sampled on the edge that leaves
// CAPTURE. done/wr_en/result are registered from the DONE state, so done is
// visible in the cycle after the edge leaving DONE (three edges after accept).
//
// Configuration macro: ALU_OVF_TRAP_EN
//   defined   -> overflow on signed add (3'b010) / sub (3'b110) enters TRAP,
//                loads epc and bumps the saturating ovf_count
//   undefined -> TRAP is unreachable; trap, epc and ovf_count stay zero and
//                trap_ack is ignored
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_ovf_ctrl_if.slave (request, ALU drive, status, trap handshake)
module alu_ovf_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_ovf_ctrl_if.slave bus
);

`ifdef ALU_OVF_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3,
        TRAP    = 3'd4
    } state_t;

    // Only signed add/sub are trap-capable; overflow elsewhere is ignored.
    function automatic logic trap_cond(input logic ovf, input logic sgn, input logic [2:0] op);
        return ovf && sgn && ((op == OP_ADD) || (op == OP_SUB));
    endfunction

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t            state_r;
    state_t            next_s;

    logic [2:0]        op_r;
    logic              sgn_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  pc_r;
    logic [WIDTH-1:0]  res_cap_r;

    logic              done_r;
    logic              wr_en_r;
    logic [WIDTH-1:0]  result_r;
    logic              trap_r;
    logic [WIDTH-1:0]  epc_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              busy_s;
    logic              done_s;
    logic [2:0]        alu_op_s;
    logic [WIDTH-1:0]  alu_a_s;
    logic [WIDTH-1:0]  alu_b_s;
    logic              enter_trap_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; req is only looked at in IDLE, so it is ignored elsewhere.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    next_s = ISSUE;
                end else begin
                    next_s = IDLE;
                end
            end
            ISSUE: begin
                next_s = CAPTURE;
            end
            CAPTURE: begin
                if (TRAP_EN && trap_cond(bus.overflow, sgn_r, op_r)) begin
                    next_s = TRAP;
                end else begin
                    next_s = DONE;
                end
            end
            DONE: begin
                next_s = IDLE;
            end
            TRAP: begin
                if (bus.trap_ack) begin
                    next_s = IDLE;
                end else begin
                    next_s = TRAP;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State-decoded outputs: ALU drive during ISSUE/CAPTURE, busy outside IDLE.
    always_comb begin
        busy_s   = 1'b1;
        done_s   = 1'b0;
        alu_op_s = 3'b000;
        alu_a_s  = {WIDTH{1'b0}};
        alu_b_s  = {WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            ISSUE, CAPTURE: begin
                alu_op_s = op_r;
                alu_a_s  = a_r;
                alu_b_s  = b_r;
            end
            DONE: begin
                done_s = 1'b1;
            end
            TRAP: begin
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign enter_trap_s = (state_r == CAPTURE) && (next_s == TRAP);

    // Operand capture on acceptance and ALU result capture at the end of CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r      <= 3'b000;
            sgn_r     <= 1'b0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            pc_r      <= {WIDTH{1'b0}};
            res_cap_r <= {WIDTH{1'b0}};
        end else begin
            if ((state_r == IDLE) && bus.req) begin
                op_r  <= bus.op_in;
                sgn_r <= bus.op_signed;
                a_r   <= bus.A;
                b_r   <= bus.B;
                pc_r  <= bus.pc_in;
            end
            if (state_r == CAPTURE) begin
                res_cap_r <= bus.alu_res;
            end
        end
    end

    // Completion outputs: one-cycle done/wr_en pulse, result held between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r   <= 1'b0;
            wr_en_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            done_r  <= done_s;
            wr_en_r <= done_s;
            if (done_s) begin
                result_r <= res_cap_r;
            end
        end
    end

    // Trap flag, exception PC and saturating overflow-event counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_r <= 1'b0;
            epc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            trap_r <= (next_s == TRAP);
            if (enter_trap_s) begin
                epc_r <= pc_r;
                cnt_r <= sat_inc(cnt_r);
            end
        end
    end

    assign bus.ALU_operation = alu_op_s;
    assign bus.alu_A         = alu_a_s;
    assign bus.alu_B         = alu_b_s;
    assign bus.busy          = busy_s;
    assign bus.done          = done_r;
    assign bus.wr_en         = wr_en_r;
    assign bus.result        = result_r;
    assign bus.trap          = trap_r;
    assign bus.epc           = epc_r;
    assign bus.ovf_count     = cnt_r;

endmodule

// File: doc/alu_ovf_ctrl.md
ALU_OVF_CTRL -- requirements
Module: alu_ovf_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter CNT_W, default 8, meaning overflow-event counter width.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-005 SHALL have ports req in 1 (operation request), op_in in 3 (ALU operation code), op_signed in 1 (trap-capable signed op), A in WIDTH, B in WIDTH, pc_in in WIDTH (PC of requesting instruction).
REQ-006 SHALL have ports ALU_operation out 3, alu_A out WIDTH, alu_B out WIDTH (drive ALU), alu_res in WIDTH, overflow in 1 (from overflow checker).
REQ-007 SHALL have ports busy out 1, done out 1, result out WIDTH, wr_en out 1, trap out 1, epc out WIDTH, trap_ack in 1, ovf_count out CNT_W.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, CAPTURE, DONE, TRAP.
REQ-009 SHALL, in IDLE with req=1, register op_in, op_signed, A, B, pc_in and enter ISSUE; req in any other state SHALL be ignored.
REQ-010 SHALL drive ALU_operation/alu_A/alu_B from the registered values during ISSUE and CAPTURE, and ALU_operation=3'b000, operands 0 otherwise.
REQ-011 SHALL go ISSUE -> CAPTURE unconditionally, sampling alu_res and overflow at the end of CAPTURE.
REQ-012 SHALL go CAPTURE -> TRAP when trap condition holds (REQ-016), else CAPTURE -> DONE.
REQ-013 SHALL, in DONE, assert done=1 and wr_en=1 for exactly one cycle with result=captured alu_res, then return to IDLE.
REQ-014 SHALL yield done exactly 3 cycles after the accepting req edge (accept at edge n, done high in cycle after edge n+3).
REQ-015 SHALL assert busy=1 in every state except IDLE.
REQ-016 Trap condition SHALL be overflow=1 AND op_signed=1 AND registered op in {3'b010, 3'b110}; overflow on any other op or with op_signed=0 SHALL be ignored.
REQ-017 SHALL, on entering TRAP, load epc with the registered pc, hold trap=1, keep wr_en=0 and done=0, and leave result unchanged.
REQ-018 SHALL leave TRAP for IDLE on the first cycle trap_ack=1; trap SHALL drop on that edge; epc SHALL hold until the next trap.
REQ-019 SHALL increment ovf_count by 1 on each TRAP entry, saturating at all-ones (no wrap).
REQ-020 SHALL hold result at its last written value between operations.
REQ-021 trap_ack outside TRAP SHALL have no effect; req and trap_ack simultaneously in TRAP SHALL clear trap only, req not accepted.

Reset
REQ-022 SHALL, on rst=1 at any time, asynchronously force state IDLE, busy=0, done=0, wr_en=0, trap=0, result=0, epc=0, ovf_count=0, ALU_operation=0, alu_A=0, alu_B=0.
REQ-023 SHALL abandon any in-flight operation on reset with no done, wr_en or trap pulse afterwards.

Configuration
REQ-024 With macro ALU_OVF_TRAP_EN defined, SHALL behave per REQ-012, REQ-016 to REQ-019.
REQ-025 Without ALU_OVF_TRAP_EN, SHALL never enter TRAP: CAPTURE always -> DONE with wr_en=1, trap=0, epc=0, ovf_count=0 constant, trap_ack ignored.

Verification
REQ-026 op_in=010, signed, A=5, B=7 -> done 3 cycles later, result=12, wr_en=1, trap=0.
REQ-027 op_in=010, signed, A=32'h7FFFFFFF, B=1, pc_in=32'h0040_0010 -> trap=1, wr_en=0, epc=32'h0040_0010, ovf_count=1; trap_ack -> IDLE, busy=0.
REQ-028 op_in=110, unsigned, A=32'h80000000, B=1 -> no trap, result=32'h7FFFFFFF, wr_en=1.
REQ-029 Back-to-back req held high -> accepted only in IDLE, one done per 4 cycles; req during busy ignored.
REQ-030 rst asserted mid-CAPTURE -> outputs zero immediately, no later done/trap; 300 forced traps with CNT_W=8 -> ovf_count=255.
REQ-031 Build without ALU_OVF_TRAP_EN, repeat REQ-027 stimulus -> result=32'h80000000, wr_en=1, trap=0.
